// File: rtl/resp_misr_checker.sv
// Response-side MISR checker: compacts SAMPLES result words into a signature and compares it with a golden value.
// Optional watchdog for stalled runs is built when RESP_CHK_TIMEOUT_EN is defined.
module resp_misr_checker #(
  parameter int unsigned            Y_WIDTH    = 233,
  parameter int unsigned            MISR_WIDTH = 32,
  parameter logic [MISR_WIDTH-1:0]  POLY       = 32'h04C11DB7,
  parameter logic [MISR_WIDTH-1:0]  SEED       = 32'hFFFFFFFF,
  parameter int unsigned            SAMPLES    = 21,
  parameter int unsigned            TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  y_valid_i,
  input  logic [Y_WIDTH-1:0]    y_i,
  input  logic [MISR_WIDTH-1:0] golden_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [MISR_WIDTH-1:0] signature_o,
  output logic [15:0]           sample_cnt_o
);

  localparam int unsigned NWORDS = (Y_WIDTH + MISR_WIDTH - 1) / MISR_WIDTH;
  localparam int unsigned FOLD_W = NWORDS * MISR_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_e;

  state_e                state_q, state_d;
  logic [MISR_WIDTH-1:0] sig_q, sig_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  pass_q, pass_d;
  logic                  busy_q, done_q;
  logic                  reseed;

  // XOR of all MISR-wide words of the zero-extended sample; word 0 is the LSBs.
  function automatic logic [MISR_WIDTH-1:0] fold(input logic [Y_WIDTH-1:0] v);
    logic [FOLD_W-1:0]     ext;
    logic [MISR_WIDTH-1:0] acc;
    ext = '0;
    ext[Y_WIDTH-1:0] = v;
    acc = '0;
    for (int i = 0; i < NWORDS; i++) begin
      acc = acc ^ ext[i*MISR_WIDTH +: MISR_WIDTH];
    end
    return acc;
  endfunction

  function automatic logic [MISR_WIDTH-1:0] misr_next(input logic [MISR_WIDTH-1:0] s,
                                                      input logic [Y_WIDTH-1:0]    v);
    return {s[MISR_WIDTH-2:0], 1'b0} ^ (s[MISR_WIDTH-1] ? POLY : '0) ^ fold(v);
  endfunction

`ifdef RESP_CHK_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_q, timeout_d;
`else
  logic timeout_unused;
  assign timeout_unused = |TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    reseed  = 1'b0;
`ifdef RESP_CHK_TIMEOUT_EN
    idle_d    = idle_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_i) reseed = 1'b1;
      end
      RUN: begin
        if (start_i) begin
          reseed = 1'b1;
        end else if (y_valid_i) begin
          sig_d = misr_next(sig_q, y_i);
          cnt_d = cnt_q + 16'd1;
`ifdef RESP_CHK_TIMEOUT_EN
          idle_d = '0;
`endif
          if (cnt_q == 16'(SAMPLES - 1)) state_d = CHECK;
        end else begin
`ifdef RESP_CHK_TIMEOUT_EN
          // A sample on the would-be timeout cycle wins, so only idle cycles can fire the watchdog.
          if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            state_d   = DONE;
            pass_d    = 1'b0;
            timeout_d = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
`endif
        end
      end
      CHECK: begin
        if (start_i) begin
          reseed = 1'b1;
        end else begin
          pass_d  = (sig_q == golden_i);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reseed) begin
      state_d = RUN;
      sig_d   = SEED;
      cnt_d   = '0;
      pass_d  = 1'b0;
`ifdef RESP_CHK_TIMEOUT_EN
      idle_d    = '0;
      timeout_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      busy_q  <= (state_d == RUN) || (state_d == CHECK);
      done_q  <= (state_d == DONE);
    end
  end

`ifdef RESP_CHK_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign signature_o  = sig_q;
  assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_resp_misr_checker.sv
// Self-checking bench for resp_misr_checker: spec vectors on a SAMPLES=1 instance, randomized runs on a SAMPLES=21 one.
// The watchdog section follows RESP_CHK_TIMEOUT_EN as the design does.
module tb_resp_misr_checker;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         yValid = 1'b0;
  logic [232:0] y = '0;
  logic [31:0]  golden = '0;

  logic        d1Busy, d1Done, d1Pass, d1Timeout;
  logic [31:0] d1Sig;
  logic [15:0] d1Cnt;
  logic        dBusy, dDone, dPass, dTimeout;
  logic [31:0] dSig;
  logic [15:0] dCnt;

  int total = 0;
  int bad = 0;
  int doneRises = 0;
  logic prevDone = 1'b0;

  always #5 clk = ~clk;

  resp_misr_checker #(.SAMPLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .y_valid_i(yValid), .y_i(y), .golden_i(golden),
    .busy_o(d1Busy), .done_o(d1Done), .pass_o(d1Pass), .timeout_o(d1Timeout),
    .signature_o(d1Sig), .sample_cnt_o(d1Cnt));

  resp_misr_checker #(.SAMPLES(21), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .y_valid_i(yValid), .y_i(y), .golden_i(golden),
    .busy_o(dBusy), .done_o(dDone), .pass_o(dPass), .timeout_o(dTimeout),
    .signature_o(dSig), .sample_cnt_o(dCnt));

  // Count rising edges of done on the 21-sample instance.
  always @(posedge clk) begin
    if (dDone && !prevDone) doneRises <= doneRises + 1;
    prevDone <= dDone;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=hung required=finished");
    $fatal(1, "[TB] global time limit");
  end

  // Reference: the fold is the XOR of 32-bit chunks, and each step multiplies by x modulo POLY.
  function automatic logic [31:0] foldModel(input logic [232:0] v);
    logic [255:0] w;
    logic [31:0]  acc;
    w = {23'd0, v};
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      acc = acc ^ w[31:0];
      w = w >> 32;
    end
    return acc;
  endfunction

  function automatic logic [31:0] stepModel(input logic [31:0] s, input logic [232:0] v);
    logic [32:0] t;
    t = {s, 1'b0};
    if (t[32]) t = t ^ {1'b1, POLY};
    return t[31:0] ^ foldModel(v);
  endfunction

  function automatic logic [232:0] randWord();
    logic [255:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[232:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [232:0] word);
    start = s;
    yValid = v;
    y = word;
    tick();
    start = 1'b0;
    yValid = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy"}, 64'(dBusy), 64'd0);
    checkOutput({tag, " done"}, 64'(dDone), 64'd0);
    checkOutput({tag, " pass"}, 64'(dPass), 64'd0);
    checkOutput({tag, " timeout"}, 64'(dTimeout), 64'd0);
    checkOutput({tag, " sig"}, 64'(dSig), 64'(SEED));
    checkOutput({tag, " cnt"}, 64'(dCnt), 64'd0);
  endtask

  typedef struct {
    logic [232:0] word;
    logic [31:0]  gold;
    logic [31:0]  expSig;
    logic         expPass;
  } vec_t;

  vec_t tbl[6];
  logic [232:0] samples[21];
  logic [31:0]  expSig;
  logic [31:0]  holdSig;
  int           risesBefore;

  initial begin
    tbl[0] = '{233'd0, 32'hFB3EE249, 32'hFB3EE249, 1'b1};
    tbl[1] = '{233'd1, 32'hFB3EE248, 32'hFB3EE248, 1'b1};
    tbl[2] = '{(233'd1 << 32), 32'hFB3EE248, 32'hFB3EE248, 1'b1};
    tbl[3] = '{(233'd1 << 232), 32'hFB3EE349, 32'hFB3EE349, 1'b1};
    tbl[4] = '{(233'd1 << 32), 32'h00000000, 32'hFB3EE248, 1'b0};
    tbl[5].word = randWord();
    tbl[5].expSig = stepModel(SEED, tbl[5].word);
    tbl[5].gold = tbl[5].expSig;
    tbl[5].expPass = 1'b1;

    tick();
    tick();
    rst = 1'b0;
    checkResetState("reset");

    // Single-sample runs with 2-cycle verdict latency.
    for (int i = 0; i < 6; i++) begin
      golden = tbl[i].gold;
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput($sformatf("v%0d busy", i), 64'(d1Busy), 64'd1);
      checkOutput($sformatf("v%0d seed", i), 64'(d1Sig), 64'(SEED));
      applyStimulus(1'b0, 1'b1, tbl[i].word);
      checkOutput($sformatf("v%0d sig", i), 64'(d1Sig), 64'(tbl[i].expSig));
      checkOutput($sformatf("v%0d early done", i), 64'(d1Done), 64'd0);
      tick();
      checkOutput($sformatf("v%0d done", i), 64'(d1Done), 64'd1);
      checkOutput($sformatf("v%0d pass", i), 64'(d1Pass), 64'(tbl[i].expPass));
    end

    // 21-sample run with random gaps in y_valid.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expSig = SEED;
    for (int k = 0; k < 21; k++) begin
      samples[k] = randWord();
      expSig = stepModel(expSig, samples[k]);
    end
    golden = expSig;
    risesBefore = doneRises;
    applyStimulus(1'b1, 1'b0, '0);
    begin
      int k = 0;
      int gap = 0;
      while (k < 21) begin
        if (gap < 2 && $urandom_range(0, 2) == 0) begin
          yValid = 1'b0;
          gap++;
        end else begin
          yValid = 1'b1;
          y = samples[k];
          k++;
          gap = 0;
        end
        tick();
      end
      yValid = 1'b0;
    end
    checkOutput("gap cnt", 64'(dCnt), 64'd21);
    checkOutput("gap sig", 64'(dSig), 64'(expSig));
    checkOutput("gap busy in check", 64'(dBusy), 64'd1);
    tick();
    checkOutput("gap done", 64'(dDone), 64'd1);
    checkOutput("gap pass", 64'(dPass), 64'd1);
    checkOutput("gap busy after", 64'(dBusy), 64'd0);

    // y_valid in DONE must not disturb the result.
    for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b1, randWord());
    checkOutput("done hold sig", 64'(dSig), 64'(expSig));
    checkOutput("done hold cnt", 64'(dCnt), 64'd21);
    checkOutput("done hold done", 64'(dDone), 64'd1);
    checkOutput("done rises", 64'(doneRises - risesBefore), 64'd1);

    // Gap-free rerun of the same samples from DONE, wrong golden.
    golden = expSig ^ 32'h1;
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("rerun cnt cleared", 64'(dCnt), 64'd0);
    for (int k = 0; k < 21; k++) applyStimulus(1'b0, 1'b1, samples[k]);
    checkOutput("rerun sig", 64'(dSig), 64'(expSig));
    tick();
    checkOutput("rerun done", 64'(dDone), 64'd1);
    checkOutput("rerun pass", 64'(dPass), 64'd0);

    // start together with y_valid mid-run restarts and drops that sample.
    applyStimulus(1'b1, 1'b0, '0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, samples[k]);
    applyStimulus(1'b1, 1'b1, samples[5]);
    checkOutput("restart cnt", 64'(dCnt), 64'd0);
    checkOutput("restart sig", 64'(dSig), 64'(SEED));
    checkOutput("restart busy", 64'(dBusy), 64'd1);
    applyStimulus(1'b0, 1'b1, samples[6]);
    checkOutput("restart next sig", 64'(dSig), 64'(stepModel(SEED, samples[6])));

    // rst mid-run discards everything.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, samples[k]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkResetState("midrst");

    // y_valid in IDLE is ignored.
    for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b1, randWord());
    checkOutput("idle sig", 64'(dSig), 64'(SEED));
    checkOutput("idle cnt", 64'(dCnt), 64'd0);
    checkOutput("idle busy", 64'(dBusy), 64'd0);

`ifdef RESP_CHK_TIMEOUT_EN
    applyStimulus(1'b1, 1'b0, '0);
    for (int j = 0; j < 3; j++) tick();
    checkOutput("wd still run", 64'(dBusy), 64'd1);
    checkOutput("wd no done yet", 64'(dDone), 64'd0);
    tick();
    checkOutput("wd done", 64'(dDone), 64'd1);
    checkOutput("wd timeout", 64'(dTimeout), 64'd1);
    checkOutput("wd pass", 64'(dPass), 64'd0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("wd restart clears", 64'(dTimeout), 64'd0);
    for (int j = 0; j < 3; j++) tick();
    applyStimulus(1'b0, 1'b1, samples[0]);
    checkOutput("wd late sample busy", 64'(dBusy), 64'd1);
    checkOutput("wd late sample cnt", 64'(dCnt), 64'd1);
    checkOutput("wd late sample timeout", 64'(dTimeout), 64'd0);
    for (int j = 0; j < 3; j++) tick();
    checkOutput("wd rearmed busy", 64'(dBusy), 64'd1);
`else
    applyStimulus(1'b1, 1'b0, '0);
    for (int j = 0; j < 80; j++) tick();
    checkOutput("no wd busy", 64'(dBusy), 64'd1);
    checkOutput("no wd timeout", 64'(dTimeout), 64'd0);
    checkOutput("no wd done", 64'(dDone), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/resp_misr_checker.md
# resp_misr_checker

Synthesizable response-side checker that sits on the DUT output bus of an identity/equivalence run and consumes one wide result word per clock. It compacts every accepted sample into a 32-bit multiple-input signature register (MISR) and compares the final signature against a golden value after a fixed sample count. A pass/fail verdict is produced without per-cycle `$strobe` logging, so the checker can run in hardware or in long regressions.

## Interface
- `Y_WIDTH`, 233: width of the DUT result bus.
- `MISR_WIDTH`, 32: signature width.
- `POLY`, 32'h04C11DB7: MISR feedback polynomial.
- `SEED`, 32'hFFFFFFFF: signature value loaded on `start`.
- `SAMPLES`, 21: samples per run; legal range 1..65535.
- `TIMEOUT`, 64: idle-cycle limit; used only with `RESP_CHK_TIMEOUT_EN`.

- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins or restarts a run.
- `y_valid`  in  1  `y` holds a sample this cycle.
- `y`  in  Y_WIDTH  DUT result sample.
- `golden`  in  MISR_WIDTH  expected signature; sampled in CHECK.
- `busy`  out  1  high in RUN and CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  verdict; valid while `done`.
- `timeout`  out  1  run ended by watchdog.
- `signature`  out  MISR_WIDTH  current MISR value.
- `sample_cnt`  out  16  samples accepted in the current run.

## Operation
- States: IDLE, RUN, CHECK, DONE.
- IDLE: `start` -> RUN; `signature`<=SEED; `sample_cnt`<=0; `pass`<=0; `timeout`<=0.
- RUN: on `y_valid`, `signature`<=next and `sample_cnt`++. If `sample_cnt`==SAMPLES-1 and `y_valid`, go to CHECK.
- CHECK: `pass`<=(`signature`==`golden`); go to DONE. `y_valid` is ignored.
- DONE: outputs hold. `start` -> RUN with reseed, same as from IDLE.
- Fold: zero-extend `y` to a multiple of 32 bits (256 for the default width). XOR all 32-bit words; word 0 is `y[31:0]`.
- Next signature: `{sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold(y)`.
- `start` in RUN or CHECK restarts the run (reseed, count cleared). `start` has priority over a concurrent `y_valid`, and that sample is discarded.
- `y_valid` in IDLE or DONE is ignored.
- `sample_cnt` never exceeds SAMPLES.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `signature`=SEED, `sample_cnt`=0.
- `rst` asserted in any state, mid-run included, forces the reset values on the next edge and discards any partial signature.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `busy` rises the edge after `start`.
- Call the edge that accepts the last sample E. CHECK holds after E. `done` and the final `pass` hold after E+1, giving a 2-cycle verdict latency.
- `golden` must be stable during the CHECK cycle.
- Back-to-back `y_valid` is accepted every cycle, with no stall or backpressure.

## Configuration
- `RESP_CHK_TIMEOUT_EN` defined: a watchdog counts consecutive RUN cycles without `y_valid`.
  - It clears on entry to RUN and on each accepted sample.
  - When it reaches TIMEOUT, the state goes to DONE with `pass`=0 and `timeout`=1.
  - A `y_valid` arriving on the would-be timeout cycle is accepted and the timeout does not fire.
- Not defined: no watchdog logic is built, `timeout` is tied to 0, and RUN waits indefinitely.

## Test plan
- SAMPLES=1, `start`, then `y`=0 with `y_valid` -> `signature`=32'hFB3EE249. With `golden`=32'hFB3EE249: `done`=1 and `pass`=1 two edges after the sample.
- SAMPLES=1, `y` with only bit 0 set -> 32'hFB3EE248. With only bit 32 set -> 32'hFB3EE248 (fold check). With only bit 232 set -> 32'hFB3EE349. With `golden`=0: `pass`=0.
- SAMPLES=21 with gaps in `y_valid` -> `sample_cnt` reaches 21, `done` asserts once, and the signature matches a gap-free run of the same 21 samples.
- `start` together with `y_valid` mid-run -> `sample_cnt`=0, `signature`=SEED, and that sample is not absorbed. `rst` mid-run -> all reset values the next cycle.
- With `RESP_CHK_TIMEOUT_EN` and TIMEOUT=4: `start`, then no `y_valid` -> DONE after 4 idle RUN cycles with `timeout`=1 and `pass`=0. A `y_valid` on the 4th idle cycle -> sample accepted, still RUN.
- `y_valid` pulses in IDLE and DONE -> `signature` and `sample_cnt` unchanged.
